// File: rtl/inst_fetch_if.sv
// Fetch-stage bus: run control, program-counter input, memory load port and
// the registered instruction/status outputs presented to decode.
interface inst_fetch_if #(
    parameter int IW = 9,
    parameter int AW = 8
);
    logic          Start;
    logic [AW-1:0] ProgCtr;
    logic          Flush;
    logic          Stall;
    logic          LoadEn;
    logic [AW-1:0] LoadAddr;
    logic [IW-1:0] LoadData;
    logic [IW-1:0] Instruction;
    logic          InstValid;
    logic [AW-1:0] InstAddr;
    logic          Done;
    logic          Busy;
    logic [15:0]   FetchCount;

    modport master (
        output Start, ProgCtr, Flush, Stall, LoadEn, LoadAddr, LoadData,
        input  Instruction, InstValid, InstAddr, Done, Busy, FetchCount
    );

    modport slave (
        input  Start, ProgCtr, Flush, Stall, LoadEn, LoadAddr, LoadData,
        output Instruction, InstValid, InstAddr, Done, Busy, FetchCount
    );
endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch stage: instruction memory with idle-time load port,
// registered fetch toward decode, and IDLE/RUN/HALT run sequencing.
module inst_fetch #(
    parameter int            IW      = 9,
    parameter int            AW      = 8,
    parameter logic [IW-1:0] HALT_OP = 9'h1FF
) (
    input logic         Clk,
    input logic         Reset,
    inst_fetch_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;

    logic [IW-1:0] mem [0:(1<<AW)-1];
    logic [IW-1:0] fetch_word_p0;
    logic          fetch_en;
    logic          count_clr;
    logic          load_ok;

    logic [IW-1:0] instr_p1;
    logic [AW-1:0] addr_p1;
    logic          vld_p1;
    logic [15:0]   count;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Memory is only writable while the core is not running; contents survive reset.
    assign load_ok = bus.LoadEn && (state != RUN);

    always_ff @(posedge Clk) begin
        if (load_ok) begin
            mem[bus.LoadAddr] <= bus.LoadData;
        end
    end

    // Stage p0: memory read at the current program counter.
    assign fetch_word_p0 = mem[bus.ProgCtr];

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        fetch_en  = 1'b0;
        count_clr = 1'b0;
        case (state)
            IDLE: begin
                if (bus.Start) begin
                    state_nxt = RUN;
                    count_clr = 1'b1;
                end
            end
            RUN: begin
                // A flushed halt word is not a real halt; it was on the wrong path.
                if (!bus.Flush && !bus.Stall) begin
                    fetch_en = 1'b1;
                    if (fetch_word_p0 == HALT_OP) begin
                        state_nxt = HALT;
                    end
                end
            end
            HALT: begin
                if (bus.Start) begin
                    state_nxt = RUN;
                    count_clr = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Stage p1: registered instruction presented to decode.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            instr_p1 <= '0;
            addr_p1  <= '0;
            vld_p1   <= 1'b0;
            count    <= '0;
        end else begin
            if (count_clr) begin
                count <= '0;
            end
            if (state == RUN) begin
                if (bus.Flush) begin
                    vld_p1 <= 1'b0;
                end else if (fetch_en) begin
                    instr_p1 <= fetch_word_p0;
                    addr_p1  <= bus.ProgCtr;
                    vld_p1   <= 1'b1;
                    count    <= sat_inc(count);
                end
            end else begin
                vld_p1 <= 1'b0;
            end
        end
    end

    assign bus.Instruction = instr_p1;
    assign bus.InstAddr    = addr_p1;
    assign bus.InstValid   = vld_p1;
    assign bus.FetchCount  = count;
    assign bus.Done        = (state == HALT);
    assign bus.Busy        = (state == RUN);

endmodule

// File: tb/tb_inst_fetch.sv
// Randomized and directed bench for inst_fetch against a behavioural model
// of the fetch stage's run/halt rules and instruction memory.
module tb_inst_fetch;

    logic Clk;
    logic Reset;

    inst_fetch_if #(.IW(9), .AW(8)) bus ();

    inst_fetch #(.IW(9), .AW(8), .HALT_OP(9'h1FF)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model state
    logic [8:0]  mm [0:255];
    bit          m_running;
    bit          m_halted;
    logic [8:0]  m_instr;
    logic [7:0]  m_addr;
    logic        m_vld;
    logic [15:0] m_cnt;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_instr"}, 32'(bus.Instruction), 32'(m_instr));
        chk({tag, "_vld"},   32'(bus.InstValid),   32'(m_vld));
        chk({tag, "_addr"},  32'(bus.InstAddr),    32'(m_addr));
        chk({tag, "_done"},  32'(bus.Done),        32'(m_halted));
        chk({tag, "_busy"},  32'(bus.Busy),        32'(m_running));
        chk({tag, "_cnt"},   32'(bus.FetchCount),  32'(m_cnt));
    endtask

    task automatic model_reset();
        m_running = 0;
        m_halted  = 0;
        m_instr   = '0;
        m_addr    = '0;
        m_vld     = 0;
        m_cnt     = '0;
    endtask

    // Apply one clock edge's worth of behaviour using the inputs now on the bus.
    task automatic model_step();
        logic [8:0] w;
        if (!Reset) begin
            model_reset();
            return;
        end
        if (!m_running) begin
            if (bus.LoadEn) mm[bus.LoadAddr] = bus.LoadData;
            m_vld = 0;
            if (bus.Start) begin
                m_running = 1;
                m_halted  = 0;
                m_cnt     = 0;
            end
        end else if (bus.Flush) begin
            m_vld = 0;
        end else if (!bus.Stall) begin
            w       = mm[bus.ProgCtr];
            m_instr = w;
            m_addr  = bus.ProgCtr;
            m_vld   = 1;
            if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
            if (w == 9'h1FF) begin
                m_running = 0;
                m_halted  = 1;
            end
        end
    endtask

    task automatic step(input string tag);
        model_step();
        @(posedge Clk);
        #1;
        check_all(tag);
    endtask

    task automatic quiet();
        bus.Start  = 0;
        bus.Flush  = 0;
        bus.Stall  = 0;
        bus.LoadEn = 0;
    endtask

    initial begin
        logic [8:0] d;
        Reset        = 0;
        bus.ProgCtr  = '0;
        bus.LoadAddr = '0;
        bus.LoadData = '0;
        quiet();
        model_reset();
        #12;
        chk("rst_instr", 32'(bus.Instruction), 0);
        chk("rst_vld",   32'(bus.InstValid),   0);
        chk("rst_addr",  32'(bus.InstAddr),    0);
        chk("rst_done",  32'(bus.Done),        0);
        chk("rst_busy",  32'(bus.Busy),        0);
        chk("rst_cnt",   32'(bus.FetchCount),  0);
        Reset = 1;

        // Fill the whole memory, with directed words at the test addresses.
        for (int a = 0; a < 256; a++) begin
            case (a)
                0: d = 9'h011;
                1: d = 9'h022;
                2: d = 9'h033;
                3: d = 9'h1FF;
                5: d = 9'h055;
                8: d = 9'h1FF;
                default: d = 9'($urandom_range(0, 510));
            endcase
            bus.LoadEn   = 1;
            bus.LoadAddr = 8'(a);
            bus.LoadData = d;
            step("load");
        end
        bus.LoadEn = 0;

        // Load, run, halt
        bus.Start = 1;
        step("t1_start");
        bus.Start = 0;
        for (int i = 0; i < 4; i++) begin
            bus.ProgCtr = 8'(i);
            step("t1_fetch");
        end
        chk("t1_last_instr", 32'(bus.Instruction), 32'h1FF);
        chk("t1_last_vld",   32'(bus.InstValid),   1);
        chk("t1_done",       32'(bus.Done),        1);
        chk("t1_count",      32'(bus.FetchCount),  4);
        bus.ProgCtr = 8'd4;
        step("t1_post");
        chk("t1_vld_drop", 32'(bus.InstValid), 0);

        // Flush bubble
        bus.Start = 1;
        step("t2_start");
        bus.Start   = 0;
        bus.ProgCtr = 8'd4;
        step("t2_pre");
        bus.ProgCtr = 8'd5;
        bus.Flush   = 1;
        step("t2_flush");
        chk("t2_flush_vld",  32'(bus.InstValid),   0);
        chk("t2_flush_hold", 32'(bus.Instruction), 32'(mm[4]));
        bus.Flush = 0;
        step("t2_refetch");
        chk("t2_refetch_instr", 32'(bus.Instruction), 32'h055);
        chk("t2_refetch_cnt",   32'(bus.FetchCount),  2);

        // Stall hold
        bus.ProgCtr = 8'd1;
        step("t3_fetch");
        bus.Stall = 1;
        for (int i = 0; i < 3; i++) begin
            bus.ProgCtr = 8'($urandom_range(10, 255));
            step("t3_stall");
            chk("t3_instr", 32'(bus.Instruction), 32'h022);
            chk("t3_vld",   32'(bus.InstValid),   1);
            chk("t3_cnt",   32'(bus.FetchCount),  3);
        end
        bus.Stall = 0;

        // Flushed halt
        bus.ProgCtr = 8'd8;
        bus.Flush   = 1;
        step("t4_flush_halt");
        chk("t4_done", 32'(bus.Done), 0);
        chk("t4_busy", 32'(bus.Busy), 1);
        bus.Flush   = 0;
        bus.ProgCtr = 8'd9;
        step("t4_next");
        chk("t4_next_vld", 32'(bus.InstValid), 1);

        // Load guard in RUN
        bus.ProgCtr  = 8'd2;
        bus.LoadEn   = 1;
        bus.LoadAddr = 8'd0;
        bus.LoadData = 9'h0AA;
        step("t6_run_load");
        bus.LoadEn  = 0;
        bus.ProgCtr = 8'd0;
        step("t6_guard");
        chk("t6_guard_instr", 32'(bus.Instruction), 32'h011);
        bus.ProgCtr = 8'd3;
        step("t6_halt");
        chk("t6_halt_done", 32'(bus.Done), 1);

        // Load in HALT, then restart
        bus.LoadEn   = 1;
        bus.LoadAddr = 8'd0;
        bus.LoadData = 9'h0AA;
        step("t6_halt_load");
        bus.LoadEn = 0;
        bus.Start  = 1;
        step("t6_restart");
        bus.Start   = 0;
        bus.ProgCtr = 8'd0;
        step("t6_refetch");
        chk("t6_load_instr", 32'(bus.Instruction), 32'h0AA);
        chk("t6_load_cnt",   32'(bus.FetchCount),  1);

        // Asynchronous reset mid-run
        bus.ProgCtr = 8'd1;
        step("t5_f1");
        bus.ProgCtr = 8'd2;
        step("t5_f2");
        #2;
        Reset = 0;
        #1;
        model_step();
        check_all("t5_async");
        chk("t5_async_vld", 32'(bus.InstValid), 0);
        step("t5_hold_a");
        step("t5_hold_b");
        #2;
        Reset = 1;
        bus.Start = 1;
        step("t5_start");
        bus.Start   = 0;
        bus.ProgCtr = 8'd1;
        step("t5_refetch");
        chk("t5_mem_kept", 32'(bus.Instruction), 32'h022);
        chk("t5_cnt",      32'(bus.FetchCount),  1);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            bus.Start    = ($urandom_range(0, 15) == 0);
            bus.Flush    = ($urandom_range(0, 6) == 0);
            bus.Stall    = ($urandom_range(0, 6) == 0);
            bus.LoadEn   = ($urandom_range(0, 3) == 0);
            bus.LoadAddr = 8'($urandom_range(0, 255));
            bus.LoadData = ($urandom_range(0, 7) == 0) ? 9'h1FF : 9'($urandom_range(0, 510));
            bus.ProgCtr  = 8'($urandom_range(0, 255));
            step("rnd");
        end
        quiet();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
